core_writeback: RTL and testbench
=================================

# core_writeback

Writeback stage of the core, directly upstream of the register file. Merges ALU and memory-unit results into one registered write port (`wr_r`/`wr_enable`/`wr_value`), buffering ALU results in a small FIFO while the memory unit has the port. Keeps a per-register pending-write scoreboard so issue logic can stall on RAW/WAW hazards.

## Interface
- `FIFO_DEPTH`, 2: ALU result FIFO entries; power of two, ≥2.
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, synchronous, active-low
- `alu_valid`  in  1  ALU result available
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` is also high
- `alu_rd`  in  `reg_num`  ALU destination
- `alu_value`  in  `word`  ALU result
- `mem_valid`  in  1  load result available; always accepted
- `mem_rd`  in  `reg_num`  load destination
- `mem_value`  in  `word`  load data
- `issue_valid`  in  1  instruction with a destination issued this cycle
- `issue_rd`  in  `reg_num`  its destination
- `busy`  out  16  pending-write bitmap, bit r = register r
- `wr_r`  out  `reg_num`  to register file
- `wr_enable`  out  1  to register file
- `wr_value`  out  `word`  to register file

## Operation
- Single write-port arbiter, fixed priority: memory > FIFO head > (bypass) ALU input.
- `mem_valid` high: the memory result goes to the output registers; the FIFO holds.
- Otherwise, FIFO non-empty: the head is popped and goes to the output registers.
- ALU push: `alu_valid && alu_ready`; `alu_ready = !full`. Push and pop in the same cycle are legal when full: `alu_ready` stays low when full; pop frees the slot for the next cycle.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits and wrap modulo 2·`FIFO_DEPTH`. Full is MSBs differ with low bits equal; empty is pointers equal.
- Scoreboard set: `busy[issue_rd]` set on `issue_valid`.
- Scoreboard clear: `busy[wr_r]` cleared in the cycle after `wr_enable` is asserted. That is the same edge the register file commits.
- Same register set and cleared on the same edge: set wins.
- Issuing to a register whose `busy` bit is already set is a protocol violation. Upstream stalls; this block does not track multiple outstanding writes.
- Reset mid-operation flushes FIFO contents and clears the scoreboard. Nothing in flight is written.

## Timing
- Reset values: `wr_enable`=0, `wr_r`=0, `wr_value`=0, `busy`=0, FIFO empty. `alu_ready` is forced to 0 while `rst_n`=0 and is 1 in the first cycle after release.
- Memory result presented in cycle N: `wr_enable` high in N+1.
- ALU result via FIFO, accepted in N: earliest write is N+2. Each cycle of `mem_valid` delays it by one more.
- `wr_enable` is high for exactly one cycle per result. Throughput is one write per cycle.
- `busy` is a registered output, updated on each clock edge.
- `alu_ready` is combinational from FIFO state only, never from `alu_valid`.

## Configuration
- `CORE_WB_BYPASS_EN` defined: if the FIFO is empty and `mem_valid`=0, a valid ALU result skips the FIFO and is written at N+1.
- `CORE_WB_BYPASS_EN` undefined: ALU results always pass through the FIFO (N+2 minimum). Smaller and with a shorter critical path.

## Structure
- `reg_num`, `word` and the register count (16) live in the shared core µarch package. Add `wb_entry` there: struct of `reg_num r` and `word value`.
- One sub-module: `core_wb_fifo`, the parameterised synchronous FIFO of `wb_entry` (push/pop/full/empty).
- Arbiter, output registers and scoreboard live in `core_writeback`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs, then release → all outputs 0, `alu_ready`=0 during reset and 1 the cycle after.
- Memory only: `mem_valid`, `mem_rd`=3, `mem_value`=0xDEADBEEF in cycle N → `wr_enable`=1, `wr_r`=3, `wr_value`=0xDEADBEEF in N+1 only.
- Priority/backpressure: `mem_valid` held 4 cycles while ALU pushes r1=1, r2=2, r3=3 → `alu_ready` drops after 2 pushes. Then writes occur in order: mem ×4, then r1, r2, r3. No loss or reorder.
- Bypass: FIFO empty, no mem, ALU r5=0x55 in N → write in N+1 with macro, N+2 without.
- Scoreboard: `issue_rd`=7 in N → `busy[7]`=1 from N+1. Write to r7 in M → `busy[7]`=0 at M+1. Re-issue of r7 on the clearing edge → stays 1.
- Mid-operation reset: FIFO full and `busy`=0x00F0, then assert `rst_n`=0 for 1 cycle → no further writes, `busy`=0, FIFO empty.

Source files
------------

// File: rtl/core_writeback_pkg.sv
// Shared core micro-architecture types: register numbers, data words, writeback entries.
// Used by the writeback stage (optional bypass: CORE_WB_BYPASS_EN) and its result FIFO.
package core_writeback_pkg;

  localparam int NUM_REGS = 16;

  typedef logic [3:0]  reg_num;
  typedef logic [31:0] word;

  typedef struct packed {
    reg_num r;
    word    value;
  } wb_entry;

endpackage

// File: rtl/core_writeback_if.sv
// Writeback stage bundle: ALU/memory results and issue in, register-file write port and busy bitmap out.
// master = upstream/pipeline side, slave = writeback stage.
interface core_writeback_if;
  import core_writeback_pkg::*;

  logic                alu_valid;
  logic                alu_ready;
  reg_num              alu_rd;
  word                 alu_value;
  logic                mem_valid;
  reg_num              mem_rd;
  word                 mem_value;
  logic                issue_valid;
  reg_num              issue_rd;
  logic [NUM_REGS-1:0] busy;
  reg_num              wr_r;
  logic                wr_enable;
  word                 wr_value;

  modport master (
    output alu_valid, alu_rd, alu_value, mem_valid, mem_rd, mem_value, issue_valid, issue_rd,
    input  alu_ready, busy, wr_r, wr_enable, wr_value
  );

  modport slave (
    input  alu_valid, alu_rd, alu_value, mem_valid, mem_rd, mem_value, issue_valid, issue_rd,
    output alu_ready, busy, wr_r, wr_enable, wr_value
  );

endinterface

// File: rtl/core_wb_fifo.sv
// Synchronous FIFO of writeback entries; head visible combinationally, push ignored when full.
// Push and pop may coincide; pointers carry one extra wrap bit to tell full from empty.
module core_wb_fifo
  import core_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_entry push_data,
  input  logic    pop,
  output wb_entry pop_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  wb_entry       mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/core_writeback.sv
// Writeback stage: memory > FIFO head > ALU bypass onto one registered write port, plus pending-write scoreboard.
// Loads write at N+1, ALU via FIFO at N+2 (N+1 with CORE_WB_BYPASS_EN); alu_ready drops only when the FIFO is full.
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  core_writeback_if.slave  bus
);

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                take_alu;
  logic                bypass;
  wb_entry             alu_entry;
  wb_entry             head;
  wb_entry             next_entry;
  logic                next_enable;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;
  reg_num              wr_r_q;
  word                 wr_value_q;
  logic                wr_enable_q;

  assign alu_entry     = '{r: bus.alu_rd, value: bus.alu_value};
  assign bus.alu_ready = rst_n && !fifo_full;
  assign take_alu      = bus.alu_valid && bus.alu_ready;
  assign fifo_pop      = !bus.mem_valid && !fifo_empty;

`ifdef CORE_WB_BYPASS_EN
  assign bypass = take_alu && fifo_empty && !bus.mem_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = take_alu && !bypass;

  core_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (alu_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    next_entry  = head;
    next_enable = bus.mem_valid || fifo_pop || bypass;
    if (bus.mem_valid) begin
      next_entry = '{r: bus.mem_rd, value: bus.mem_value};
    end else if (bypass) begin
      next_entry = alu_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_enable_q <= 1'b0;
      wr_r_q      <= '0;
      wr_value_q  <= '0;
    end else begin
      wr_enable_q <= next_enable;
      if (next_enable) begin
        wr_r_q     <= next_entry.r;
        wr_value_q <= next_entry.value;
      end
    end
  end

  // Clear applies first so a same-edge re-issue of the register keeps it busy.
  always_comb begin
    busy_next = busy_q;
    if (wr_enable_q)     busy_next[wr_r_q]       = 1'b0;
    if (bus.issue_valid) busy_next[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign bus.busy      = busy_q;
  assign bus.wr_r      = wr_r_q;
  assign bus.wr_value  = wr_value_q;
  assign bus.wr_enable = wr_enable_q;

endmodule

// File: tb/tb_core_writeback.sv
// Bench for core_writeback: table-driven arbitration vectors, hand sequences, write scoreboard queue.
module tb_core_writeback;
  import core_writeback_pkg::*;

`ifdef CORE_WB_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_writeback_if bus ();

  core_writeback #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int     cyc;
    reg_num r;
    word    value;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic   mem_v;
    reg_num mem_rd;
    word    mem_val;
    logic   alu_v;
    reg_num alu_rd;
    word    alu_val;
    logic   exp_ready;
    logic   exp_v;
    int     exp_lat;
    reg_num exp_r;
    word    exp_val;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_value   = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_rd      = '0;
    bus.mem_value   = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic drive_mem(input reg_num r, input word v);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = r;
    bus.mem_value = v;
    sbq.push_back('{cyc: cyc + 1, r: r, value: v});
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  // Write monitor: every write must match the oldest expectation, at its predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_enable === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr actual r=%0d value=0x%0h expected no write (cycle %0d)",
                 bus.wr_r, bus.wr_value, cyc);
      end else begin
        e = sbq.pop_front();
        chk("wr_r", 32'(bus.wr_r), 32'(e.r));
        chk("wr_value", bus.wr_value, e.value);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_wr actual no write expected r=%0d value=0x%0h at cycle %0d",
               e.r, e.value, e.cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  vec_t tbl[7];

  initial begin
    // mem held 4 cycles while ALU offers r1, r2, r3; FIFO fills after two pushes
    tbl[0] = '{1'b1, 4'd8,  32'h100, 1'b1, 4'd1, 32'd1, 1'b1, 1'b1, 1, 4'd8,  32'h100};
    tbl[1] = '{1'b1, 4'd9,  32'h101, 1'b1, 4'd2, 32'd2, 1'b1, 1'b1, 1, 4'd9,  32'h101};
    tbl[2] = '{1'b1, 4'd10, 32'h102, 1'b1, 4'd3, 32'd3, 1'b0, 1'b1, 1, 4'd10, 32'h102};
    tbl[3] = '{1'b1, 4'd11, 32'h103, 1'b1, 4'd3, 32'd3, 1'b0, 1'b1, 1, 4'd11, 32'h103};
    tbl[4] = '{1'b0, 4'd0,  32'h0,   1'b1, 4'd3, 32'd3, 1'b0, 1'b1, 1, 4'd1,  32'd1};
    tbl[5] = '{1'b0, 4'd0,  32'h0,   1'b1, 4'd3, 32'd3, 1'b1, 1'b1, 1, 4'd2,  32'd2};
    tbl[6] = '{1'b0, 4'd0,  32'h0,   1'b0, 4'd0, 32'd0, 1'b1, 1'b1, 1, 4'd3,  32'd3};

    rst_n = 1'b0;
    idle();

    // Reset with random inputs
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.alu_valid   = 1'($urandom_range(0, 1));
      bus.alu_rd      = 4'($urandom);
      bus.alu_value   = $urandom;
      bus.mem_valid   = 1'($urandom_range(0, 1));
      bus.mem_rd      = 4'($urandom);
      bus.mem_value   = $urandom;
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 4'($urandom);
      @(negedge clk);
      chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
      chk("rst_wr_enable", 32'(bus.wr_enable), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("rel_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rel_wr_enable", 32'(bus.wr_enable), 32'd0);
    chk("rel_wr_r", 32'(bus.wr_r), 32'd0);
    chk("rel_wr_value", bus.wr_value, 32'd0);
    chk("rel_busy", 32'(bus.busy), 32'd0);

    // Memory only
    tick();
    drive_mem(4'd3, 32'hDEADBEEF);
    tick();
    idle();
    repeat (3) tick();
    drain("drain_mem");

    // Priority / backpressure table
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.mem_valid = tbl[i].mem_v;
      bus.mem_rd    = tbl[i].mem_rd;
      bus.mem_value = tbl[i].mem_val;
      bus.alu_valid = tbl[i].alu_v;
      bus.alu_rd    = tbl[i].alu_rd;
      bus.alu_value = tbl[i].alu_val;
      if (tbl[i].exp_v)
        sbq.push_back('{cyc: cyc + tbl[i].exp_lat, r: tbl[i].exp_r, value: tbl[i].exp_val});
      @(negedge clk);
      chk($sformatf("tbl%0d_alu_ready", i), 32'(bus.alu_ready), 32'(tbl[i].exp_ready));
    end
    tick();
    idle();
    repeat (2) tick();
    drain("drain_tbl");

    // ALU into empty FIFO with no memory traffic
    tick();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 4'd5;
    bus.alu_value = 32'h55;
    sbq.push_back('{cyc: cyc + BYP_LAT, r: 4'd5, value: 32'h55});
    @(negedge clk);
    chk("byp_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    idle();
    repeat (3) tick();
    drain("drain_byp");

    // Scoreboard set / clear / set-wins
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 4'd7;
    @(negedge clk);
    chk("sb_busy_same_cycle", 32'(bus.busy), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("sb_busy_set", 32'(bus.busy), 32'h0080);
    tick();
    drive_mem(4'd7, 32'h77);
    tick();
    idle();
    @(negedge clk);
    chk("sb_busy_during_wr", 32'(bus.busy), 32'h0080);
    tick();
    @(negedge clk);
    chk("sb_busy_cleared", 32'(bus.busy), 32'h0000);
    tick();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 4'd7;
    tick();
    idle();
    tick();
    drive_mem(4'd7, 32'h78);
    tick();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 4'd7;
    tick();
    idle();
    @(negedge clk);
    chk("sb_set_wins", 32'(bus.busy), 32'h0080);
    tick();
    drive_mem(4'd7, 32'h79);
    tick();
    idle();
    tick();
    @(negedge clk);
    chk("sb_final_clear", 32'(bus.busy), 32'h0000);
    drain("drain_sb");

    // Mid-operation reset with FIFO full and busy = 0x00F0
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'(4 + i);
      drive_mem(4'(12 + i), 32'hC00 + 32'(i));
      if (i < 2) begin
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'(1 + i);
        bus.alu_value = 32'hA1 + 32'(i);
      end
      @(negedge clk);
      chk($sformatf("mid%0d_alu_ready", i), 32'(bus.alu_ready), (i < 2) ? 32'd1 : 32'd0);
    end
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", 32'(bus.busy), 32'h00F0);
    chk("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_busy_after", 32'(bus.busy), 32'h0000);
    chk("mid_alu_ready_after", 32'(bus.alu_ready), 32'd1);
    chk("mid_wr_enable_after", 32'(bus.wr_enable), 32'd0);
    repeat (4) tick();
    drain("drain_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
